// File: rtl/uart_hex_history_display.sv
// Keeps a ring of recently received UART bytes, shows a scrollable window of them
// on a multiplexed hex display, and can retransmit the byte at the window's start.
module uart_hex_history_display #(
  parameter  int DEPTH        = 8,
  parameter  int BYTES_SHOWN  = 2,
  parameter  int REFRESH_BITS = 18,
  localparam int ND           = 2 * BYTES_SHOWN,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             up_tick,
  input  logic             down_tick,
  input  logic             send_tick,
  input  logic             mode,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [CNT_W-1:0] count,
  output logic [ND-1:0]    an,
  output logic [7:0]       sseg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DIG_W = $clog2(ND);
  localparam logic [DIG_W:0]   ND_L    = (DIG_W + 1)'(ND);
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   BS_L    = (CNT_W + 1)'(BYTES_SHOWN);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;

  logic [7:0]              ring [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        offset_reg;
  logic [CNT_W-1:0]        offset_next;
  logic [CNT_W:0]          offset_sum;
  logic [CNT_W:0]          offset_limit;
  logic [REFRESH_BITS-1:0] refresh_reg;
  tx_state_t               state_reg;
  tx_state_t               state_next;
  logic                    tx_load;
  logic [PTR_W-1:0]        tx_idx;

  logic [DIG_W-1:0]        dig_raw;
  logic [DIG_W-1:0]        dig;
  logic [CNT_W-1:0]        disp_age;
  logic                    disp_empty;
  logic [PTR_W-1:0]        disp_idx;
  logic [7:0]              disp_byte;
  logic [3:0]              disp_nibble;
  logic                    dp_lit;
  logic [6:0]              seg7;
  logic [ND-1:0]           an_next;
  logic [7:0]              sseg_next;

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Ring storage has no reset; entries beyond count are never displayed or sent.
  always_ff @(posedge clk) begin
    if (rx_valid) ring[wr_ptr_reg] <= rx_data;
  end

  always_comb begin
    count_next = count;
    if (rx_valid && count != DEPTH_L) count_next = count + CNT_W'(1);
  end

  // Offset follows writes so a browsed window stays frozen; limit uses the post-write count.
  always_comb begin
    offset_limit = ({1'b0, count_next} > BS_L) ? ({1'b0, count_next} - BS_L) : '0;
    offset_sum   = {1'b0, offset_reg} + (CNT_W + 1)'(rx_valid) + (CNT_W + 1)'(up_tick);
    if (down_tick && offset_sum != '0) offset_sum = offset_sum - (CNT_W + 1)'(1);
    if (!mode)                         offset_next = '0;
    else if (offset_sum > offset_limit) offset_next = offset_limit[CNT_W-1:0];
    else                               offset_next = offset_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      count       <= '0;
      offset_reg  <= '0;
      refresh_reg <= '0;
    end else begin
      if (rx_valid) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      count       <= count_next;
      offset_reg  <= offset_next;
      refresh_reg <= refresh_reg + REFRESH_BITS'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    tx_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (send_tick && count != '0) begin
          tx_load    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: if (tx_busy)  state_next = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tx_idx = wr_ptr_reg - PTR_W'(1) - offset_reg[PTR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      tx_data   <= '0;
    end else begin
      state_reg <= state_next;
      if (tx_load) tx_data <= ring[tx_idx];
    end
  end

  // Digit select from the scan counter's top bits; out-of-range indices fold to digit 0.
  always_comb begin
    dig_raw     = refresh_reg[REFRESH_BITS-1 -: DIG_W];
    dig         = ({1'b0, dig_raw} >= ND_L) ? '0 : dig_raw;
    disp_age    = offset_reg + CNT_W'(dig >> 1);
    disp_empty  = (disp_age >= count);
    disp_idx    = wr_ptr_reg - PTR_W'(1) - disp_age[PTR_W-1:0];
    disp_byte   = ring[disp_idx];
    disp_nibble = dig[0] ? disp_byte[7:4] : disp_byte[3:0];
    // Digit 0 dp flags browse mode; other even digits separate bytes when populated.
    dp_lit      = (dig == '0) ? mode : (!dig[0] && !disp_empty);
    seg7        = disp_empty ? 7'h7F : hex7(disp_nibble);
    sseg_next   = {~dp_lit, seg7};
    an_next     = ~(ND'(1) << dig);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule

// File: tb/tb_uart_hex_history_display.sv
// Directed and randomized checks of the UART history display against a
// queue-based model of the byte history, scroll offset and digit contents.
module tb_uart_hex_history_display;
  localparam int DEPTH = 8;
  localparam int BS    = 2;
  localparam int RB    = 4;
  localparam int ND    = 2 * BS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       up_tick = 1'b0;
  logic       down_tick = 1'b0;
  logic       send_tick = 1'b0;
  logic       mode = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] count;
  logic [3:0] an;
  logic [7:0] sseg;

  uart_hex_history_display #(.DEPTH(DEPTH), .BYTES_SHOWN(BS), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .up_tick(up_tick), .down_tick(down_tick), .send_tick(send_tick),
    .mode(mode), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .count(count), .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tx_pulses = 0;
  logic [7:0] hist[$];   // hist[0] is the newest byte
  int m_off = 0;

  always @(negedge clk) if (tx_start === 1'b1) tx_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic logic [7:0] exp_digit(input int d);
    int age = m_off + d / 2;
    logic [7:0] s;
    logic [7:0] b;
    logic lit;
    if (age >= hist.size()) begin
      s   = 8'hFF;
      lit = (d == 0) && mode;
    end else begin
      b   = hist[age];
      s   = hex_seg((d % 2 == 1) ? b[7:4] : b[3:0]);
      lit = ((d == 0) && mode) || ((d % 2 == 0) && (d >= 2));
    end
    if (lit) s[7] = 1'b0;
    return s;
  endfunction

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic step(input logic rv, input logic [7:0] data, input logic up,
                      input logic dn, input logic snd);
    int lim;
    int t;
    rx_valid = rv; rx_data = data; up_tick = up; down_tick = dn; send_tick = snd;
    @(posedge clk);
    if (rv) begin
      hist.push_front(data);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    if (!mode) m_off = 0;
    else begin
      lim = (hist.size() > BS) ? hist.size() - BS : 0;
      t = m_off + int'(rv) + int'(up) - int'(dn);
      if (t < 0) t = 0;
      if (t > lim) t = lim;
      m_off = t;
    end
    @(negedge clk);
    rx_valid = 1'b0; up_tick = 1'b0; down_tick = 1'b0; send_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input string tag);
    logic [3:0] seen = 4'h0;
    int d;
    idle(2);
    for (int i = 0; i < ND * (1 << (RB - 2)) + 4; i++) begin
      check({tag, "_an_onehot"}, 32'($countones(~an)), 32'd1);
      if ($countones(~an) == 1) begin
        d = 0;
        for (int k = 0; k < ND; k++) if (an[k] == 1'b0) d = k;
        seen[d] = 1'b1;
        check($sformatf("%s_d%0d", tag, d), 32'(sseg), 32'(exp_digit(d)));
      end
      @(negedge clk);
    end
    check({tag, "_all_digits"}, 32'(seen), 32'hF);
  endtask

  initial begin
    int p0;
    logic [7:0] exp_tx;

    idle(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b1;
    idle(1);

    // Empty buffer in browse mode
    mode = 1'b1;
    p0 = tx_pulses;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("empty_send", 32'(tx_pulses), 32'(p0));
    scan("empty_browse");

    // Two bytes, live mode
    mode = 1'b0;
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("live2_count", 32'(count), 32'd2);
    scan("live2");

    // Saturating history and retransmit handshake
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("sat_count", 32'(count), 32'd8);
    p0 = tx_pulses;
    exp_tx = hist[m_off];
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("send1_pulse", 32'(tx_pulses), 32'(p0 + 1));
    check("send1_data", 32'(tx_data), 32'(exp_tx));
    tx_busy = 1'b1;
    idle(2);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("busy_send_pulse", 32'(tx_pulses), 32'(p0 + 1));
    check("busy_send_data", 32'(tx_data), 32'(exp_tx));
    tx_busy = 1'b0;
    idle(2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("send2_pulse", 32'(tx_pulses), 32'(p0 + 2));
    check("send2_data", 32'(tx_data), 32'hEE);
    tx_busy = 1'b1;
    idle(2);
    tx_busy = 1'b0;
    idle(2);

    // Browse scrolling
    mode = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    scan("up9");
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    scan("updown");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    scan("off2");
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    scan("browse_write");
    mode = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    scan("back_live");

    // Randomized traffic and scrolling
    for (int r = 0; r < 25; r++) begin
      mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < 8; c++)
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      check($sformatf("rand%0d_count", r), 32'(count), 32'(hist.size()));
      scan($sformatf("rand%0d", r));
    end

    // Reset while waiting for tx_busy
    mode = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    p0 = tx_pulses;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("prereset_pulse", 32'(tx_pulses), 32'(p0 + 1));
    rst = 1'b0;
    #2;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_sseg", 32'(sseg), 32'hFF);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    hist.delete();
    m_off = 0;
    idle(2);
    rst = 1'b1;
    p0 = tx_pulses;
    idle(40);
    tx_busy = 1'b1;
    idle(20);
    tx_busy = 1'b0;
    idle(40);
    check("postrst_quiet", 32'(tx_pulses), 32'(p0));
    step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("postrst_send_pulse", 32'(tx_pulses), 32'(p0 + 1));
    check("postrst_send_data", 32'(tx_data), 32'h5C);
    scan("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
